// File: rtl/phys_reg_free_list_if.sv
// phys_reg_free_list_if: dispatch/ROB-facing signals of the physical register free list.
// The free list itself uses the slave modport; rename/commit logic drives through master.
interface phys_reg_free_list_if #(
    parameter int TAG_W = 6,
    parameter int CNT_W = 7,
    parameter int COL_W = 2
);
    logic             dequeue_valid;
    logic [TAG_W-1:0] dequeue_phys_reg_tag;
    logic             dequeue;
    logic             enqueue;
    logic [TAG_W-1:0] enqueue_phys_reg_tag;
    logic             save_checkpoint_valid;
    logic [COL_W-1:0] save_checkpoint_column;
    logic             restore_checkpoint_valid;
    logic [COL_W-1:0] restore_checkpoint_column;
    logic [CNT_W-1:0] free_count;

    modport master (
        input  dequeue_valid, dequeue_phys_reg_tag, free_count,
        output dequeue, enqueue, enqueue_phys_reg_tag,
               save_checkpoint_valid, save_checkpoint_column,
               restore_checkpoint_valid, restore_checkpoint_column
    );

    modport slave (
        output dequeue_valid, dequeue_phys_reg_tag, free_count,
        input  dequeue, enqueue, enqueue_phys_reg_tag,
               save_checkpoint_valid, save_checkpoint_column,
               restore_checkpoint_valid, restore_checkpoint_column
    );
endinterface

// File: rtl/phys_reg_free_list.sv
// phys_reg_free_list: circular FIFO of free physical register tags with
// checkpointed read pointers so a mispredict returns speculatively allocated tags.
module phys_reg_free_list #(
    parameter int NUM_PHYS_REGS      = 64,
    parameter int NUM_ARCH_REGS      = 32,
    parameter int FREE_LIST_DEPTH    = NUM_PHYS_REGS,
    parameter int CHECKPOINT_COLUMNS = 4
) (
    input logic                 CLK,
    input logic                 nRST,
    phys_reg_free_list_if.slave fl
);
    localparam int TAG_W = $clog2(NUM_PHYS_REGS);
    localparam int IDX_W = $clog2(FREE_LIST_DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam int INIT_FREE = NUM_PHYS_REGS - NUM_ARCH_REGS;

    logic [TAG_W-1:0] slots_q [FREE_LIST_DEPTH];
    logic [PTR_W-1:0] ckpt_q  [CHECKPOINT_COLUMNS];
    logic [PTR_W-1:0] ckpt_d  [CHECKPOINT_COLUMNS];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, count;
    logic             empty, full, deq_ok, enq_ok;

    // A restore owns the head this cycle, so a concurrent dequeue is dropped
    // and a concurrent save would race the restored value; both are suppressed.
    always_comb begin
        count  = tail_q - head_q;
        empty  = count == '0;
        full   = count == PTR_W'(FREE_LIST_DEPTH);
        deq_ok = fl.dequeue && !empty && !fl.restore_checkpoint_valid;
        enq_ok = fl.enqueue && (!full || deq_ok);
        head_d = fl.restore_checkpoint_valid ? ckpt_q[fl.restore_checkpoint_column]
                                             : head_q + PTR_W'(deq_ok);
        tail_d = tail_q + PTR_W'(enq_ok);
        ckpt_d = ckpt_q;
        if (fl.save_checkpoint_valid && !fl.restore_checkpoint_valid)
            ckpt_d[fl.save_checkpoint_column] = head_d;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            head_q <= '0;
            tail_q <= PTR_W'(INIT_FREE);
            for (int c = 0; c < CHECKPOINT_COLUMNS; c++)
                ckpt_q[c] <= '0;
            for (int i = 0; i < FREE_LIST_DEPTH; i++)
                slots_q[i] <= (i < INIT_FREE) ? TAG_W'(NUM_ARCH_REGS + i) : '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            ckpt_q <= ckpt_d;
            if (enq_ok)
                slots_q[tail_q[IDX_W-1:0]] <= fl.enqueue_phys_reg_tag;
        end
    end

    assign fl.dequeue_valid        = !empty;
    assign fl.dequeue_phys_reg_tag = slots_q[head_q[IDX_W-1:0]];
    assign fl.free_count           = count;
endmodule

// File: tb/tb_phys_reg_free_list.sv
// tb_phys_reg_free_list: directed checks of the free list FIFO, wrap and checkpoint behaviour.
module tb_phys_reg_free_list;
    logic CLK = 1'b0;
    logic nRST = 1'b0;
    int checks = 0;
    int errors = 0;

    phys_reg_free_list_if fl();
    phys_reg_free_list dut (.CLK(CLK), .nRST(nRST), .fl(fl));

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // t < 0 skips the head tag, whose value is meaningless when the list is empty
    task automatic expect_state(input string tag, input int v, input int t, input int c);
        check({tag, ".valid"}, int'(fl.dequeue_valid), v);
        check({tag, ".count"}, int'(fl.free_count), c);
        if (t >= 0) check({tag, ".tag"}, int'(fl.dequeue_phys_reg_tag), t);
    endtask

    task automatic idle();
        fl.dequeue = 0;
        fl.enqueue = 0;
        fl.enqueue_phys_reg_tag = '0;
        fl.save_checkpoint_valid = 0;
        fl.save_checkpoint_column = '0;
        fl.restore_checkpoint_valid = 0;
        fl.restore_checkpoint_column = '0;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        idle();
        @(negedge CLK);
        nRST = 0;
        @(negedge CLK);
        nRST = 1;
        step();
    endtask

    initial begin
        int model[$];
        int pool[$];
        bit d, e, deq_acc, enq_acc;
        idle();
        // reset values
        do_reset();
        expect_state("reset", 1, 32, 32);

        // test 1: three dequeues
        fl.dequeue = 1;
        for (int k = 0; k < 3; k++) begin
            check("t1.head", int'(fl.dequeue_phys_reg_tag), 32 + k);
            step();
            check("t1.valid", int'(fl.dequeue_valid), 1);
        end
        idle();
        expect_state("t1.end", 1, 35, 29);

        // test 2: drain, dequeue on empty, enqueue+dequeue on empty
        do_reset();
        fl.dequeue = 1;
        repeat (32) step();
        expect_state("t2.drained", 0, -1, 0);
        step();
        expect_state("t2.deq_empty", 0, -1, 0);
        fl.enqueue = 1;
        fl.enqueue_phys_reg_tag = 6'd5;
        step();
        idle();
        expect_state("t2.enq_empty", 1, 5, 1);

        // test 3: fill to full, dropped enqueue, enqueue+dequeue on full
        do_reset();
        fl.enqueue = 1;
        for (int i = 0; i < 32; i++) begin
            fl.enqueue_phys_reg_tag = 6'(i);
            step();
        end
        expect_state("t3.full", 1, 32, 64);
        fl.enqueue_phys_reg_tag = 6'd40;
        step();
        expect_state("t3.drop", 1, 32, 64);
        fl.enqueue_phys_reg_tag = 6'd41;
        fl.dequeue = 1;
        step();
        expect_state("t3.enq_deq_full", 1, 33, 64);
        fl.enqueue = 0;
        for (int k = 0; k < 64; k++) begin
            check("t3.drain", int'(fl.dequeue_phys_reg_tag), k < 31 ? 33 + k : (k < 63 ? k - 31 : 41));
            step();
        end
        idle();
        expect_state("t3.empty", 0, -1, 0);

        // test 4: save with dequeue, more dequeues, restore
        do_reset();
        fl.save_checkpoint_valid = 1;
        fl.save_checkpoint_column = 2'd2;
        fl.dequeue = 1;
        step();
        fl.save_checkpoint_valid = 0;
        for (int k = 0; k < 4; k++) begin
            check("t4.deq", int'(fl.dequeue_phys_reg_tag), 33 + k);
            step();
        end
        idle();
        expect_state("t4.before", 1, 37, 27);
        fl.restore_checkpoint_valid = 1;
        fl.restore_checkpoint_column = 2'd2;
        step();
        idle();
        expect_state("t4.restore", 1, 33, 31);

        // test 5: restore beats dequeue, restore beats save, restore with enqueue
        fl.dequeue = 1;
        repeat (2) step();
        idle();
        expect_state("t5.adv", 1, 35, 29);
        fl.restore_checkpoint_valid = 1;
        fl.restore_checkpoint_column = 2'd2;
        fl.dequeue = 1;
        step();
        idle();
        expect_state("t5.rst_deq", 1, 33, 31);
        fl.dequeue = 1;
        repeat (2) step();
        idle();
        fl.save_checkpoint_valid = 1;
        fl.save_checkpoint_column = 2'd2;
        fl.restore_checkpoint_valid = 1;
        fl.restore_checkpoint_column = 2'd1;
        step();
        idle();
        expect_state("t5.save_rst", 1, 32, 32);
        fl.restore_checkpoint_valid = 1;
        fl.restore_checkpoint_column = 2'd2;
        step();
        idle();
        expect_state("t5.col2_kept", 1, 33, 31);
        fl.restore_checkpoint_valid = 1;
        fl.restore_checkpoint_column = 2'd0;
        fl.enqueue = 1;
        fl.enqueue_phys_reg_tag = 6'd7;
        step();
        idle();
        expect_state("t5.rst_enq", 1, 32, 33);

        // test 6: long recycled stream wrapping both pointers several times
        do_reset();
        for (int i = 0; i < 32; i++) begin
            model.push_back(32 + i);
            pool.push_back(i);
        end
        for (int i = 0; i < 300; i++) begin
            d = (i % 5) != 4;
            e = ((i % 7) != 6) && pool.size() > 0;
            fl.dequeue = d;
            fl.enqueue = e;
            fl.enqueue_phys_reg_tag = e ? 6'(pool[0]) : '0;
            check("t6.valid", int'(fl.dequeue_valid), model.size() > 0 ? 1 : 0);
            check("t6.count", int'(fl.free_count), model.size());
            if (model.size() > 0) check("t6.tag", int'(fl.dequeue_phys_reg_tag), model[0]);
            deq_acc = d && model.size() > 0;
            enq_acc = e && (model.size() < 64 || deq_acc);
            step();
            if (enq_acc) model.push_back(pool.pop_front());
            if (deq_acc) pool.push_back(model.pop_front());
        end
        // asynchronous reset while traffic is still being driven
        @(negedge CLK);
        nRST = 0;
        #1;
        expect_state("t6.async_rst", 1, 32, 32);
        idle();
        @(negedge CLK);
        nRST = 1;
        step();
        expect_state("t6.post_rst", 1, 32, 32);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
